// File: rtl/mips_fetch_seq.sv
// Purpose: multi-cycle MIPS instruction-fetch sequencer (PC, instruction register, next-PC select).
// Latency: IDLE->FETCH 1 cycle; FETCH->EXEC 1 cycle minimum after imem_valid; EXEC->FETCH/HALT 1 cycle.
// Backpressure: FETCH holds imem_req/imem_addr until imem_valid; imem_valid is ignored in all other states.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   imem_req/addr      fetch request (FETCH only) and byte address (= pc)
//   imem_rdata/valid   instruction memory response
//   control_type       decoder next-PC select: 00 seq, 01 branch taken, 10 jump, 11 jr
//   except             decoder exception (illegal / overflow)
//   rs_data            jr target source
//   inst, inst_valid   instruction register, high for the single EXEC cycle
//   opcode, funct      inst[31:26], inst[5:0]
//   pc, pc_plus4, epc  current PC, PC+4 (jal link), PC of last excepting instruction
//   halted             double fault taken; only reset exits
// Optional: define FETCH_PERF_CNT_EN to add retired_cnt (count of non-excepting retired instructions).
module mips_fetch_seq #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic [1:0]  control_type,
    input  logic        except,
    input  logic [31:0] rs_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] epc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;

    // Next-PC candidates; all arithmetic wraps modulo 2^32.
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};
    // Misaligned jr targets are forced to word alignment rather than trapped.
    assign jr_target = rs_data & 32'hFFFF_FFFC;

    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == S_EXEC);
    assign halted     = (state == S_HALT);
    assign opcode     = inst[31:26];
    assign funct      = inst[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic retire;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        epc_nxt   = epc;
        inst_nxt  = inst;
`ifdef FETCH_PERF_CNT_EN
        retire    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (except && (pc == EXC_VECTOR)) begin
                    // Faulting inside the handler itself: stop rather than loop forever.
                    epc_nxt   = pc;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_FETCH;
                    if (except) begin
                        epc_nxt = pc;
                        pc_nxt  = EXC_VECTOR;
                    end else begin
`ifdef FETCH_PERF_CNT_EN
                        retire = 1'b1;
`endif
                        case (control_type)
                            2'b00:   pc_nxt = pc_plus4;
                            2'b01:   pc_nxt = br_target;
                            2'b10:   pc_nxt = j_target;
                            default: pc_nxt = jr_target;
                        endcase
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            inst  <= 32'd0;
            epc   <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
            epc   <= epc_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_cnt <= 32'd0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_seq.sv
module tb_mips_fetch_seq;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC    = 32'h8000_0180;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [1:0]  control_type;
    logic        except;
    logic [31:0] rs_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    mips_fetch_seq dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .control_type (control_type),
        .except       (except),
        .rs_data      (rs_data),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: architectural phase, registers and expected EXEC records.
    typedef enum {P_IDLE, P_FETCH, P_EXEC, P_HALT} phase_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    phase_t      model_phase;
    logic [31:0] model_pc;
    logic [31:0] model_inst;
    logic [31:0] model_epc;
    logic [31:0] model_retired;
    rec_t        exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_phase   = P_IDLE;
        model_pc      = RST_PC;
        model_inst    = 32'd0;
        model_epc     = 32'd0;
        model_retired = 32'd0;
        exp_q.delete();
    endtask

    // Architectural next-PC rule applied at the end of EXEC.
    task automatic model_exec(input logic [31:0] iw, input logic [1:0] ct,
                              input logic ex, input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        seq = model_pc + 32'd4;
        off = int'($signed(iw[15:0])) * 4;
        if (ex && model_pc == EXC) begin
            model_epc   = model_pc;
            model_phase = P_HALT;
        end else begin
            model_phase = P_FETCH;
            if (ex) begin
                model_epc = model_pc;
                model_pc  = EXC;
            end else begin
                model_retired = model_retired + 32'd1;
                case (ct)
                    2'd0:    model_pc = seq;
                    2'd1:    model_pc = seq + 32'(off);
                    2'd2:    model_pc = {seq[31:28], iw[25:0], 2'b00};
                    default: model_pc = {rs[31:2], 2'b00};
                endcase
            end
        end
    endtask

    // Monitor: samples 3 time units after each falling edge (drivers act on the falling edge).
    always @(negedge clock) begin
        rec_t r;
        #3;
        chk("imem_req",   {31'd0, imem_req},   {31'd0, model_phase == P_FETCH});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, model_phase == P_EXEC});
        chk("halted",     {31'd0, halted},     {31'd0, model_phase == P_HALT});
        chk("pc",   pc,   model_pc);
        chk("inst", inst, model_inst);
        chk("epc",  epc,  model_epc);
`ifdef FETCH_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, model_retired);
`endif
        if (model_phase == P_FETCH) chk("imem_addr", imem_addr, model_pc);
        if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL exec_unexpected: got inst_valid=1 expected no pending instruction at %0t", $time);
            end else begin
                r = exp_q.pop_front();
                chk("exec_pc",       pc,                 r.pc);
                chk("exec_inst",     inst,               r.inst);
                chk("exec_opcode",   {26'd0, opcode},    {26'd0, r.inst[31:26]});
                chk("exec_funct",    {26'd0, funct},     {26'd0, r.inst[5:0]});
                chk("exec_pc_plus4", pc_plus4,           r.pc + 32'd4);
            end
        end
    end

    // One full FETCH->EXEC->next pass; called at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] iw, input int lat, input logic [1:0] ct,
                             input logic ex, input logic [31:0] rs, input logic stray);
        rec_t r;
        for (int k = 0; k < lat; k++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(posedge clock);
            @(negedge clock);
        end
        imem_valid = 1'b1;
        imem_rdata = iw;
        @(posedge clock);
        model_inst  = iw;
        model_phase = P_EXEC;
        r.pc   = model_pc;
        r.inst = iw;
        exp_q.push_back(r);
        @(negedge clock);
        // A response during EXEC must not disturb the instruction register.
        imem_valid   = stray;
        imem_rdata   = $urandom;
        control_type = ct;
        except       = ex;
        rs_data      = rs;
        @(posedge clock);
        model_exec(iw, ct, ex, rs);
        @(negedge clock);
        imem_valid   = 1'b0;
        except       = 1'b0;
        control_type = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            imem_valid = $urandom;
            imem_rdata = $urandom;
            @(negedge clock);
        end
        imem_valid = 1'b0;
    endtask

    task automatic release_reset();
        imem_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock);
        model_phase = P_FETCH;
        @(negedge clock);
    endtask

    // Asserts reset between edges, with a memory response still pending.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc",       pc,                   RST_PC);
        chk("async_rst_imem_req", {31'd0, imem_req},    32'd0);
        imem_valid = 1'b1;
        imem_rdata = $urandom;
        @(negedge clock);
        @(negedge clock);
        release_reset();
    endtask

    initial begin
        reset        = 1'b0;
        imem_valid   = 1'b0;
        imem_rdata   = 32'd0;
        control_type = 2'd0;
        except       = 1'b0;
        rs_data      = 32'd0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        release_reset();

        // Back-to-back sequential fetches, zero latency.
        for (int i = 0; i < 3; i++) run_instr(32'h0000_0020, 0, 2'd0, 1'b0, 32'd0, 1'b0);
        // Three-cycle latency with a stray response in EXEC.
        run_instr(32'h0000_0020, 3, 2'd0, 1'b0, 32'd0, 1'b1);
        // pc = 0x0040_0010: taken backward branch, then same branch not taken.
        run_instr(32'h1000_FFFC, 1, 2'd1, 1'b0, 32'd0, 1'b0);
        run_instr(32'h0000_0008, 0, 2'd3, 1'b0, 32'h0040_0013, 1'b0);
        run_instr(32'h1000_FFFC, 2, 2'd0, 1'b0, 32'd0, 1'b1);

        // Jump and jr from reset PC.
        do_reset();
        run_instr({6'h02, 26'h010_0040}, 0, 2'd2, 1'b0, 32'd0, 1'b0);
        run_instr(32'h0000_0008, 1, 2'd3, 1'b0, 32'h0040_0033, 1'b0);
        // PC wrap at top of address space.
        run_instr(32'h0000_0008, 0, 2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_instr(32'h0000_0020, 0, 2'd0, 1'b0, 32'd0, 1'b0);

        // Exception, then double fault inside the handler.
        do_reset();
        run_instr(32'h0000_0020, 0, 2'd0, 1'b0, 32'd0, 1'b0);
        run_instr(32'h0000_0020, 0, 2'd0, 1'b0, 32'd0, 1'b0);
        run_instr(32'hFFFF_FFFF, 1, 2'd2, 1'b1, 32'd0, 1'b0);
        run_instr(32'hFFFF_FFFF, 0, 2'd1, 1'b1, 32'd0, 1'b1);
        idle_cycles(6);
        do_reset();

        // Randomized instruction stream with occasional mid-fetch reset.
        for (int i = 0; i < 200; i++) begin
            if (model_phase == P_HALT) begin
                idle_cycles(3);
                do_reset();
            end else if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            run_instr($urandom, $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0), $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clock);
        @(negedge clock);
        #4;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_fetch_seq.md
Name: mips_fetch_seq

Overview:
Instruction-fetch sequencer sitting directly upstream of mips_decode. Holds the PC and fetches from an instruction memory that returns data after a variable latency. Latches the instruction and presents opcode/funct to the decoder. Consumes the decoder's control_type and except outputs, together with the ALU zero-qualified branch decision already folded into control_type, to select the next PC. Multi-cycle: one instruction per FETCH→EXEC pass.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset.
EXC_VECTOR, 32'h8000_0180, PC loaded when except is taken.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request, high only in FETCH.
imem_addr  out  32  byte address of the fetch; equals pc.
imem_rdata  in  32  instruction word from memory.
imem_valid  in  1  imem_rdata valid this cycle; ignored outside FETCH.
control_type  in  2  from decoder: 00 seq, 01 branch taken, 10 jump, 11 jr.
except  in  1  from decoder: illegal or overflow exception.
rs_data  in  32  register-file rs value, used as the jr target.
inst  out  32  instruction register.
inst_valid  out  1  high for exactly the single EXEC cycle.
opcode  out  6  inst[31:26].
funct  out  6  inst[5:0].
pc  out  32  address of the current instruction.
pc_plus4  out  32  pc+4, for the jal link value.
epc  out  32  PC of the last excepting instruction.
halted  out  1  high in HALT.

Behaviour:
- State machine: IDLE, FETCH, EXEC, HALT. Registered state.
- Reset (reset==0, async) sets:
  - state=IDLE, pc=RESET_PC, inst=0, epc=0.
  - inst_valid=0, halted=0, imem_req=0.
  - Takes effect immediately, mid-fetch included. A memory response arriving after reset deasserts is ignored unless the FSM is in FETCH.
- IDLE: unconditionally goes to FETCH on the next edge. imem_req=0.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_valid=0: stay in FETCH, pc unchanged.
  - imem_valid=1: inst<=imem_rdata, go to EXEC.
  - Minimum latency from entering FETCH to EXEC is 1 cycle.
- EXEC: inst_valid=1. Decoder inputs are stable all cycle. On the next edge the FSM goes to FETCH with pc updated, highest priority first:
  1. except=1 and pc==EXC_VECTOR: double fault. Go to HALT, epc<=pc, pc unchanged.
  2. except=1: epc<=pc, pc<=EXC_VECTOR. control_type is ignored.
  3. control_type 00: pc<=pc+4.
  4. control_type 01: pc<=pc+4+(sign_extend(inst[15:0])<<2).
  5. control_type 10: pc<={pc_plus4[31:28], inst[25:0], 2'b00}.
  6. control_type 11: pc<={rs_data[31:2], 2'b00}. The low two bits are silently cleared.
- HALT: absorbing. imem_req=0, inst_valid=0, halted=1. Only reset exits.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- opcode, funct and pc_plus4 are combinational from inst and pc. They are valid in every state but meaningful only while inst_valid=1.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output port retired_cnt (32-bit).
  - Reset to 0.
  - Increments by 1 on each EXEC→FETCH transition in which except=0.
  - Wraps at 2^32.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset release, imem_valid tied high, imem_rdata=32'h0000_0020 (add), control_type=00:
   - imem_addr sequence 0x0040_0000, 0x0040_0004, 0x0040_0008.
   - inst_valid pulses every 2nd cycle after IDLE.
2. Memory latency 3 cycles:
   - imem_req stays high and pc is held for 3 cycles.
   - inst latches only on the imem_valid cycle.
   - A stray imem_valid during EXEC is ignored.
3. Branch at pc=0x0040_0010, inst[15:0]=16'hFFFC, control_type=01 → next pc=0x0040_0004. Same instruction with control_type=00 → 0x0040_0014.
4. Jump and jr:
   - j with inst[25:0]=26'h010_0040 at pc=0x0040_0000 → pc=0x0040_0100.
   - jr with rs_data=0x0040_0033 → pc=0x0040_0030.
5. except=1 at pc=0x0040_0008 → epc=0x0040_0008, pc=0x8000_0180. A second except at 0x8000_0180 → halted=1, imem_req=0 permanently until reset.
6. Assert reset while in FETCH with the response pending → pc=0x0040_0000 and state IDLE immediately (asynchronous). With FETCH_PERF_CNT_EN defined, retired_cnt=0 after reset and equals 3 after three non-excepting instructions.
